// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the add/subtract arbiter: FSM state encoding,
// default operand width, client index type and the signed-overflow helper.
package addsub_arb_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Client index: 0 or 1.
  typedef logic client_idx_t;

  // Two's-complement overflow from sign bits.
  // b_msb is the raw operand bit; it is inverted here for a subtract.
  function automatic logic addsub_ovf(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_arbiter_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the last-grant pointer
// register lives in the parent. A lone request wins outright; when both
// clients request, the one not granted last (the one ptr does not name) wins.
module rr_arb2
  import addsub_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  client_idx_t ptr,
  output logic [1:0]  gnt,
  output client_idx_t next_ptr
);

  // Pick a winner and compute the pointer value that records it
  always_comb begin
    gnt      = 2'b00;
    next_ptr = ptr;
    case (req)
      2'b01: begin
        gnt      = 2'b01;
        next_ptr = 1'b0;
      end
      2'b10: begin
        gnt      = 2'b10;
        next_ptr = 1'b1;
      end
      2'b11: begin
        gnt      = ptr ? 2'b01 : 2'b10;
        next_ptr = ~ptr;
      end
      default: begin
        gnt      = 2'b00;
        next_ptr = ptr;
      end
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-client controller for one shared registered add/subtract unit.
// Sequence per operation: IDLE (arbitrate, latch operands) -> ISSUE (au_en
// strobe) -> WAIT (capture au_result/au_cout) -> RESP (done pulse).
//
// Handshake: a client raises req[i] with its operands and holds req[i] high
// until it sees done[i]; done[i] is a one-cycle pulse with rsp_* valid in the
// same cycle. Operands are latched at the grant edge, so later changes on the
// client inputs do not disturb the operation in flight.
//
// Optional feature: define ADDSUB_ARB_OVF_EN to capture signed overflow into
// rsp_ovf; otherwise rsp_ovf is constant 0.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   sub,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [W-1:0] rsp_data,
  output logic         rsp_cout,
  output logic         rsp_ovf,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic         au_sub,
  output logic         au_en,
  output logic         au_clr,
  input  logic [W-1:0] au_result,
  input  logic         au_cout
);

  state_e       state_q, state_d;
  client_idx_t  ptr_q, ptr_d;
  client_idx_t  win_q, win_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic         op_sub_q, op_sub_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_cout_q, rsp_cout_d;

  logic [1:0]   arb_gnt;
  client_idx_t  arb_next_ptr;

  rr_arb2 u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .next_ptr (arb_next_ptr)
  );

  // State register and datapath registers; pointer resets to client 1 so
  // client 0 wins the first contested request
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      win_q      <= 1'b0;
      gnt_q      <= 2'b00;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  // Next-state: one fixed pass through ISSUE/WAIT/RESP per granted request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (|req) ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: grant and operand latch in IDLE, result capture in
  // WAIT, grant release on leaving RESP
  always_comb begin
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sub_d   = op_sub_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ptr_d    = arb_next_ptr;
          win_d    = arb_gnt[1];
          gnt_d    = arb_gnt;
          op_a_d   = arb_gnt[1] ? a1 : a0;
          op_b_d   = arb_gnt[1] ? b1 : b0;
          op_sub_d = arb_gnt[1] ? sub[1] : sub[0];
        end
      end
      WAIT: begin
        rsp_data_d = au_result;
        rsp_cout_d = au_cout;
      end
      RESP: begin
        gnt_d = 2'b00;
      end
      default: ;
    endcase
  end

  // Outputs: enable strobe in ISSUE, done pulse to the winner in RESP,
  // result-register clear follows reset
  always_comb begin
    au_en  = (state_q == ISSUE);
    done   = 2'b00;
    if (state_q == RESP) begin
      done = win_q ? 2'b10 : 2'b01;
    end
    au_clr = ~clr_n;
  end

  assign gnt      = gnt_q;
  assign au_a     = op_a_q;
  assign au_b     = op_b_q;
  assign au_sub   = op_sub_q;
  assign rsp_data = rsp_data_q;
  assign rsp_cout = rsp_cout_q;

`ifdef ADDSUB_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;

  // Overflow flag captured alongside the result in WAIT
  always_comb begin
    rsp_ovf_d = rsp_ovf_q;
    if (state_q == WAIT) begin
      rsp_ovf_d = addsub_ovf(op_a_q[W-1], op_b_q[W-1], op_sub_q, au_result[W-1]);
    end
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rsp_ovf_q <= 1'b0;
    end else begin
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural model of the shared
// registered add/subtract unit. Expected results are hand-computed constants.
module tb_addsub_arbiter;

  localparam int W = 4;
`ifdef ADDSUB_ARB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         clr_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   sub;
  logic [1:0]   gnt, done;
  logic [W-1:0] rsp_data;
  logic         rsp_cout, rsp_ovf;
  logic [W-1:0] au_a, au_b;
  logic         au_sub, au_en, au_clr;
  logic [W-1:0] au_result;
  logic         au_cout;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  addsub_arbiter #(.W(W)) dut (
    .clk(clk), .clr_n(clr_n), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub(sub),
    .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .au_a(au_a), .au_b(au_b), .au_sub(au_sub), .au_en(au_en), .au_clr(au_clr),
    .au_result(au_result), .au_cout(au_cout)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared unit model: registered result with enable and clear
  always @(posedge clk) begin
    if (au_clr) begin
      au_result <= '0;
      au_cout   <= 1'b0;
    end else if (au_en) begin
      if (au_sub) {au_cout, au_result} <= {1'b0, au_a} + {1'b0, ~au_b} + 5'd1;
      else        {au_cout, au_result} <= {1'b0, au_a} + {1'b0, au_b};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a done pulse; scribble over client operands after the
  // grant edge to show the in-flight operation is unaffected.
  task automatic wait_done(output logic [1:0] d, output int cyc, output int en_cnt,
                           output logic [1:0] gnt_seen);
    d = 2'b00; cyc = 0; en_cnt = 0; gnt_seen = 2'b00;
    for (int i = 0; i < 12 && d == 2'b00; i++) begin
      tick();
      cyc++;
      if (au_en) begin
        en_cnt++;
        gnt_seen = gnt;
        a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
        a1 = W'($urandom_range(0, 15)); b1 = W'($urandom_range(0, 15));
      end
      d = done;
    end
  endtask

  task automatic run_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] ed, input logic ec,
                        input logic eo, input string tag);
    logic [1:0] d, gs, exp_oh;
    int cyc, en_cnt;
    exp_oh = (c == 0) ? 2'b01 : 2'b10;
    if (c == 0) begin a0 = a; b0 = b; end
    else        begin a1 = a; b1 = b; end
    sub[c] = s;
    req = exp_oh;
    wait_done(d, cyc, en_cnt, gs);
    check({tag, " done"}, d, exp_oh);
    check({tag, " latency"}, cyc, 3);
    check({tag, " au_en_cycles"}, en_cnt, 1);
    check({tag, " gnt"}, gs, exp_oh);
    check({tag, " data"}, rsp_data, ed);
    check({tag, " cout"}, rsp_cout, ec);
    check({tag, " ovf"}, rsp_ovf, eo & OVF_ON);
    req = 2'b00;
    tick();
    check({tag, " done_width"}, done, 2'b00);
    check({tag, " gnt_release"}, gnt, 2'b00);
  endtask

  initial begin : main
    logic [1:0] d, gs;
    int cyc, en_cnt;
    logic [W-1:0] exp_d;

    clr_n = 1'b0; req = 2'b00; sub = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // reset held two cycles
    tick(); tick();
    check("rst gnt", gnt, 2'b00);
    check("rst done", done, 2'b00);
    check("rst au_en", au_en, 1'b0);
    check("rst au_clr", au_clr, 1'b1);
    check("rst au_a", au_a, 4'h0);
    check("rst au_b", au_b, 4'h0);
    check("rst au_sub", au_sub, 1'b0);
    check("rst rsp_data", rsp_data, 4'h0);
    check("rst rsp_cout", rsp_cout, 1'b0);
    check("rst rsp_ovf", rsp_ovf, 1'b0);
    clr_n = 1'b1;
    #1;
    check("rel au_clr", au_clr, 1'b0);
    tick();
    check("idle gnt", gnt, 2'b00);

    // single-client operations
    run_op(0, 4'd8, 4'd7, 1'b0, 4'd15, 1'b0, 1'b0, "c0 8+7");
    run_op(1, 4'd8, 4'd7, 1'b1, 4'd1,  1'b1, 1'b1, "c1 8-7");
    run_op(1, 4'd1, 4'd0, 1'b1, 4'd1,  1'b1, 1'b0, "c1 1-0");
    run_op(0, 4'd7, 4'd1, 1'b0, 4'd8,  1'b0, 1'b1, "c0 7+1");
    run_op(1, 4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b1, "c1 8-1");

    // contention held for four operations: 0,1,0,1 (last grant was client 1)
    a0 = 4'd11; b0 = 4'd13; a1 = 4'd11; b1 = 4'd13; sub = 2'b10;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd14);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, cyc, en_cnt, gs);
      exp_d = exp_q.pop_front();
      check($sformatf("cont%0d done", k), d, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("cont%0d gnt", k), gs, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("cont%0d spacing", k), cyc, (k == 0) ? 3 : 4);
      check($sformatf("cont%0d data", k), rsp_data, exp_d);
      check($sformatf("cont%0d cout", k), rsp_cout, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("cont%0d ovf", k), rsp_ovf, 1'b0);
      // re-apply operands scribbled during the operation
      a0 = 4'd11; b0 = 4'd13; a1 = 4'd11; b1 = 4'd13;
    end
    req = 2'b00;
    tick();
    check("cont queue empty", exp_q.size(), 0);

    // reset during WAIT aborts with no done pulse
    a0 = 4'd3; b0 = 4'd4; sub[0] = 1'b0; req = 2'b01;
    tick();
    check("abort au_en", au_en, 1'b1);
    tick();
    check("abort in wait done", done, 2'b00);
    clr_n = 1'b0; req = 2'b00;
    #1;
    check("abort au_clr", au_clr, 1'b1);
    tick();
    check("abort done", done, 2'b00);
    check("abort gnt", gnt, 2'b00);
    check("abort rsp_data", rsp_data, 4'h0);
    check("abort au_result", au_result, 4'h0);
    clr_n = 1'b1;
    tick();
    check("post abort done", done, 2'b00);
    check("post abort au_clr", au_clr, 1'b0);

    // pointer back at client 1 after reset: contested request goes to client 0
    a0 = 4'd2; b0 = 4'd3; a1 = 4'd9; b1 = 4'd9; sub = 2'b00;
    req = 2'b11;
    wait_done(d, cyc, en_cnt, gs);
    check("post rst winner", d, 2'b01);
    check("post rst latency", cyc, 3);
    check("post rst data", rsp_data, 4'd5);
    check("post rst cout", rsp_cout, 1'b0);
    req = 2'b00;
    tick();
    run_op(1, 4'd9, 4'd9, 1'b0, 4'd2, 1'b1, 1'b1, "c1 9+9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
